// File: rtl/gvsp_pkg.sv
// Shared definitions for the GVSP transmit path.
//   arb_state_e     : packet arbiter state (IDLE / PASS / GAP)
//   PRIORITY_RR     : round-robin arbitration between the two sources
//   PRIORITY_FIXED  : source 0 wins every tie
package gvsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    localparam int PRIORITY_RR    = 0;
    localparam int PRIORITY_FIXED = 1;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer with registered outputs.
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   s_data_i/s_valid_i upstream beat
//   s_ready_o          upstream ready; registered "not full" (fewer than 2 entries)
//   m_data_o/m_valid_o downstream beat (registered, held while stalled)
//   m_ready_i          downstream ready
// One beat of latency from accepted input to m_valid_o; one beat per cycle
// while m_ready_i stays high.
module axis_skid_buffer #(
    parameter int WIDTH = 9
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             out_valid_q;
    logic             skid_valid_q;
    logic             push;

    // The skid slot only fills while the output slot is stalled, so a full
    // buffer is exactly "skid slot occupied".
    assign s_ready_o = !skid_valid_q;
    assign push      = s_valid_i && !skid_valid_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: the data registers are reset as well, not only the valid
            // flags, so the merged tdata reads as zero straight out of reset.
            out_data_q   <= '0;
            skid_data_q  <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            // NOTE: all state here is updated with non-blocking assignments so
            // every branch sees the pre-edge values of both slots.
            if (!out_valid_q || m_ready_i) begin
                if (skid_valid_q) begin
                    out_data_q   <= skid_data_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= 1'b0;
                end else begin
                    out_valid_q <= push;
                    if (push) begin
                        out_data_q <= s_data_i;
                    end
                end
            end else if (push) begin
                skid_data_q  <= s_data_i;
                skid_valid_q <= 1'b1;
            end
        end
    end

    assign m_data_o  = out_data_q;
    assign m_valid_o = out_valid_q;

endmodule

// File: rtl/gvsp_tx_arbiter.sv
// Packet-granular arbiter merging two GVSP packet sources onto one stream.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   enable                 0 blocks new grants; a packet in flight completes
//   err_clear              clears stall_err (a same-cycle set wins)
//   s0_* / s1_*            AXI-Stream sources (s0 image, s1 event/resend/control)
//   m_*                    merged AXI-Stream output (registered)
//   grant                  one-hot current owner, 2'b00 when none
//   busy                   arbiter not idle or output buffer non-empty
//   pkt_cnt0 / pkt_cnt1    wrapping per-source packet counters
//   stall_err              sticky mid-packet stall watchdog flag
module gvsp_tx_arbiter
    import gvsp_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int IFG_CYCLES     = 12,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 enable,
    input  logic                 err_clear,
    input  logic [DATA_BITS-1:0] s0_tdata,
    input  logic                 s0_tvalid,
    input  logic                 s0_tlast,
    output logic                 s0_tready,
    input  logic [DATA_BITS-1:0] s1_tdata,
    input  logic                 s1_tvalid,
    input  logic                 s1_tlast,
    output logic                 s1_tready,
    output logic [DATA_BITS-1:0] m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic [15:0]          pkt_cnt0,
    output logic [15:0]          pkt_cnt1,
    output logic                 stall_err
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e           state_q, state_d;
    logic [1:0]           grant_q;
    logic                 last_grant_q;   // 1 = s1 owned the previous packet
    logic [GAP_W-1:0]     gap_cnt_q;
    logic [WD_W-1:0]      wd_cnt_q;
    logic [15:0]          pkt_cnt0_q, pkt_cnt1_q;
    logic                 stall_err_q;

    logic                 sel_valid, sel_last;
    logic [DATA_BITS-1:0] sel_data;
    logic                 buf_ready;
    logic                 buf_valid;
    logic [DATA_BITS:0]   buf_data;
    logic                 beat, end_pkt, start, pick_s1, wd_hit;

    // Input mux driven by the registered grant; nothing is selected when idle.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        if (grant_q[1]) begin
            sel_valid = s1_tvalid;
            sel_last  = s1_tlast;
            sel_data  = s1_tdata;
        end else if (grant_q[0]) begin
            sel_valid = s0_tvalid;
            sel_last  = s0_tlast;
            sel_data  = s0_tdata;
        end
    end

    assign beat    = sel_valid && buf_ready;
    assign end_pkt = beat && sel_last;
    assign start   = (state_q == ST_IDLE) && enable && (s0_tvalid || s1_tvalid);

    // Winner of an IDLE-cycle request; on a round-robin tie the source that
    // did not own the previous packet goes first.
    always_comb begin
        pick_s1 = 1'b0;
        if (PRIORITY_MODE == PRIORITY_FIXED) begin
            pick_s1 = !s0_tvalid;
        end else if (s0_tvalid && s1_tvalid) begin
            pick_s1 = !last_grant_q;
        end else begin
            pick_s1 = s1_tvalid;
        end
    end

    // FSM: state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_PASS;
            ST_PASS: if (end_pkt) state_d = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:  if (gap_cnt_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs; only the owner sees ready, gated by buffer space.
    always_comb begin
        s0_tready = grant_q[0] && buf_ready;
        s1_tready = grant_q[1] && buf_ready;
        busy      = (state_q != ST_IDLE) || buf_valid;
    end

    // Grant ownership, inter-packet gap and packet counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            gap_cnt_q    <= '0;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
        end else begin
            if (start) begin
                grant_q <= pick_s1 ? 2'b10 : 2'b01;
            end else if (end_pkt) begin
                grant_q      <= 2'b00;
                last_grant_q <= grant_q[1];
                gap_cnt_q    <= GAP_W'(IFG_CYCLES - 1);
                if (grant_q[1]) pkt_cnt1_q <= pkt_cnt1_q + 16'd1;
                else            pkt_cnt0_q <= pkt_cnt0_q + 16'd1;
            end else if (state_q == ST_GAP && gap_cnt_q != '0) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
            end
        end
    end

    // Watchdog counts only source starvation (owner tvalid low); a beat held
    // off by downstream backpressure leaves the count untouched.
    assign wd_hit = (state_q == ST_PASS) && !sel_valid &&
                    (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_cnt_q    <= '0;
            stall_err_q <= 1'b0;
        end else begin
            if (state_q != ST_PASS || beat) begin
                wd_cnt_q <= '0;
            end else if (!sel_valid && wd_cnt_q != WD_W'(TIMEOUT_CYCLES)) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
            if (wd_hit) begin
                stall_err_q <= 1'b1;
            end else if (err_clear) begin
                stall_err_q <= 1'b0;
            end
        end
    end

    axis_skid_buffer #(
        .WIDTH (DATA_BITS + 1)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_data_i  ({sel_last, sel_data}),
        .s_valid_i (sel_valid),
        .s_ready_o (buf_ready),
        .m_data_o  (buf_data),
        .m_valid_o (buf_valid),
        .m_ready_i (m_tready)
    );

    assign m_tdata   = buf_data[DATA_BITS-1:0];
    assign m_tlast   = buf_data[DATA_BITS];
    assign m_tvalid  = buf_valid;
    assign grant     = grant_q;
    assign pkt_cnt0  = pkt_cnt0_q;
    assign pkt_cnt1  = pkt_cnt1_q;
    assign stall_err = stall_err_q;

endmodule

// File: tb/tb_gvsp_tx_arbiter.sv
// Directed bench for gvsp_tx_arbiter: reset state, single packet timing,
// round-robin order and gap, fixed priority, watchdog, enable, random
// backpressure with a per-source scoreboard, and reset mid-packet.
module tb_gvsp_tx_arbiter;

    logic        aclk, aresetn, enable, err_clear;
    logic [7:0]  s0_tdata, s1_tdata;
    logic        s0_tvalid, s0_tlast, s0_tready;
    logic        s1_tvalid, s1_tlast, s1_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [1:0]  grant;
    logic        busy, stall_err;
    logic [15:0] pkt_cnt0, pkt_cnt1;

    // Fixed-priority instance with both sources permanently requesting.
    logic [7:0]  fx_m_tdata;
    logic        fx_s0_tready, fx_s1_tready, fx_m_tvalid, fx_m_tlast;
    logic [1:0]  fx_grant;
    logic        fx_busy, fx_stall;
    logic [15:0] fx_cnt0, fx_cnt1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit         mon_on      = 1'b1;
    bit         rand_ready  = 1'b0;
    bit         prev_stall  = 1'b0;
    bit         in_pkt      = 1'b0;
    bit         fx_s1_seen  = 1'b0;
    bit         mon_src;
    logic [8:0] prev_beat;
    logic [8:0] mon_exp;
    logic [8:0] exp0_q[$];
    logic [8:0] exp1_q[$];
    int         beat_cyc_q[$];
    bit         beat_last_q[$];
    int         pkt_start_q[$];
    int         pkt_end_q[$];
    bit         pkt_src_q[$];

    gvsp_tx_arbiter #(
        .DATA_BITS(8), .IFG_CYCLES(12), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .err_clear(err_clear),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .busy(busy), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
        .stall_err(stall_err)
    );

    gvsp_tx_arbiter #(
        .DATA_BITS(8), .IFG_CYCLES(0), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(16)
    ) dut_fx (
        .aclk(aclk), .aresetn(aresetn), .enable(1'b1), .err_clear(1'b0),
        .s0_tdata(8'h55), .s0_tvalid(1'b1), .s0_tlast(1'b1), .s0_tready(fx_s0_tready),
        .s1_tdata(8'hAA), .s1_tvalid(1'b1), .s1_tlast(1'b1), .s1_tready(fx_s1_tready),
        .m_tdata(fx_m_tdata), .m_tvalid(fx_m_tvalid), .m_tlast(fx_m_tlast), .m_tready(1'b1),
        .grant(fx_grant), .busy(fx_busy), .pkt_cnt0(fx_cnt0), .pkt_cnt1(fx_cnt1),
        .stall_err(fx_stall)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: picks m_tready for the coming edge, then judges the
    // handshake that edge will perform against the per-source scoreboard.
    always @(negedge aclk) begin
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (fx_s1_tready) fx_s1_seen = 1'b1;
        if (mon_on) begin
            if (prev_stall) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_beat", 32'({m_tlast, m_tdata}), 32'(prev_beat));
            end
            if (m_tvalid && m_tready) begin
                mon_src = m_tdata[7];
                beat_cyc_q.push_back(cyc);
                beat_last_q.push_back(m_tlast);
                if (!in_pkt) begin
                    pkt_start_q.push_back(cyc);
                    pkt_src_q.push_back(mon_src);
                end
                if (m_tlast) pkt_end_q.push_back(cyc);
                in_pkt = !m_tlast;
                if (mon_src) begin
                    if (exp1_q.size() == 0) check("sb_extra_s1", 32'({m_tlast, m_tdata}), 32'hDEAD);
                    else begin
                        mon_exp = exp1_q.pop_front();
                        check("sb_s1", 32'({m_tlast, m_tdata}), 32'(mon_exp));
                    end
                end else begin
                    if (exp0_q.size() == 0) check("sb_extra_s0", 32'({m_tlast, m_tdata}), 32'hDEAD);
                    else begin
                        mon_exp = exp0_q.pop_front();
                        check("sb_s0", 32'({m_tlast, m_tdata}), 32'(mon_exp));
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Presents one beat at a negedge and returns at the negedge after the
    // edge that transferred it.
    task automatic drive_beat(input bit src, input logic [7:0] d, input bit last);
        int w = 0;
        if (src) begin
            exp1_q.push_back({last, d});
            s1_tdata = d; s1_tlast = last; s1_tvalid = 1'b1;
        end else begin
            exp0_q.push_back({last, d});
            s0_tdata = d; s0_tlast = last; s0_tvalid = 1'b1;
        end
        while (!(src ? s1_tready : s0_tready) && w < 3000) begin
            @(negedge aclk);
            w++;
        end
        check(src ? "beat_wait_s1" : "beat_wait_s0", 32'(w < 3000), 32'd1);
        @(negedge aclk);
    endtask

    task automatic send_pkt(input bit src, input int len, input int base);
        for (int i = 0; i < len; i++) drive_beat(src, {src, 7'(base + i)}, i == len - 1);
        if (src) begin s1_tvalid = 1'b0; s1_tlast = 1'b0; end
        else     begin s0_tvalid = 1'b0; s0_tlast = 1'b0; end
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        while (busy && w < 500) begin
            @(negedge aclk);
            w++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int c;
        logic [15:0] snap0, snap1;
        aresetn = 1'b0; enable = 1'b1; err_clear = 1'b0;
        s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
        s1_tdata = '0; s1_tvalid = 1'b0; s1_tlast = 1'b0;
        repeat (2) @(negedge aclk);

        // Reset state
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s0_tready", 32'(s0_tready), 32'd0);
        check("rst_s1_tready", 32'(s1_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_m_tdata", 32'(m_tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt0", 32'(pkt_cnt0), 32'd0);
        check("rst_stall", 32'(stall_err), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // s0-only 4-byte packet: output beats at c+2..c+5, grant 01 after one edge
        c = cyc;
        fork
            send_pkt(1'b0, 4, 16);
            begin
                @(negedge aclk);
                check("t2_grant", 32'(grant), 32'd1);
                check("t2_s0_tready", 32'(s0_tready), 32'd1);
                check("t2_s1_tready", 32'(s1_tready), 32'd0);
            end
        join
        wait_idle("t2_idle");
        check("t2_nbeats", 32'(beat_cyc_q.size()), 32'd4);
        check("t2_first_cyc", 32'(beat_cyc_q[0]), 32'(c + 2));
        check("t2_last_cyc", 32'(beat_cyc_q[3]), 32'(c + 5));
        check("t2_tlast_mid", 32'(beat_last_q[2]), 32'd0);
        check("t2_tlast_end", 32'(beat_last_q[3]), 32'd1);
        check("t2_cnt0", 32'(pkt_cnt0), 32'd1);
        check("t2_cnt1", 32'(pkt_cnt1), 32'd0);

        // Round robin from reset: order s0,s1,s0,s1,s0,s1 with >=13 idle cycles
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        pkt_start_q.delete(); pkt_end_q.delete(); pkt_src_q.delete();
        @(negedge aclk);
        fork
            begin send_pkt(1'b0, 3, 0);  send_pkt(1'b0, 2, 8);  send_pkt(1'b0, 4, 16); end
            begin send_pkt(1'b1, 2, 32); send_pkt(1'b1, 5, 40); send_pkt(1'b1, 1, 48); end
        join
        wait_idle("rr_idle");
        check("rr_npkts", 32'(pkt_src_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) check("rr_order", 32'(pkt_src_q[i]), 32'(i % 2));
        for (int i = 1; i < 6; i++)
            check("rr_gap_ge13", 32'((pkt_start_q[i] - pkt_end_q[i-1] - 1) >= 13), 32'd1);
        check("rr_cnt0", 32'(pkt_cnt0), 32'd3);
        check("rr_cnt1", 32'(pkt_cnt1), 32'd3);

        // Fixed priority instance: one s0 packet every 2 cycles, s1 never served
        snap0 = fx_cnt0;
        repeat (20) @(negedge aclk);
        check("fx_cnt0_rate", 32'(16'(fx_cnt0 - snap0)), 32'd10);
        check("fx_cnt1", 32'(fx_cnt1), 32'd0);
        check("fx_s1_tready_seen", 32'(fx_s1_seen), 32'd0);

        // Watchdog: s1 starves mid-packet; flag sets on the 16th idle cycle
        drive_beat(1'b1, 8'h81, 1'b0);
        s1_tvalid = 1'b0;
        repeat (15) @(negedge aclk);
        check("wd_before", 32'(stall_err), 32'd0);
        @(negedge aclk);
        check("wd_set", 32'(stall_err), 32'd1);
        check("wd_grant_kept", 32'(grant), 32'd2);
        drive_beat(1'b1, 8'h82, 1'b1);
        s1_tvalid = 1'b0; s1_tlast = 1'b0;
        check("wd_sticky", 32'(stall_err), 32'd1);
        err_clear = 1'b1;
        @(negedge aclk);
        err_clear = 1'b0;
        check("wd_cleared", 32'(stall_err), 32'd0);
        check("wd_cnt1", 32'(pkt_cnt1), 32'd4);
        wait_idle("wd_idle");

        // enable drops mid-packet: packet finishes, no new grant until enable=1
        fork
            send_pkt(1'b0, 6, 64);
            begin repeat (3) @(negedge aclk); enable = 1'b0; end
        join
        check("en_cnt0", 32'(pkt_cnt0), 32'd4);
        fork
            send_pkt(1'b1, 2, 80);
            begin
                repeat (30) @(negedge aclk);
                check("en_grant_held", 32'(grant), 32'd0);
                check("en_s1_tready", 32'(s1_tready), 32'd0);
                check("en_busy", 32'(busy), 32'd0);
                check("en_cnt1_held", 32'(pkt_cnt1), 32'd4);
                enable = 1'b1;
            end
        join
        wait_idle("en_idle");
        check("en_cnt1", 32'(pkt_cnt1), 32'd5);

        // Random backpressure over 1000 random-length packets
        snap0 = pkt_cnt0;
        snap1 = pkt_cnt1;
        rand_ready = 1'b1;
        fork
            for (int i = 0; i < 500; i++)
                send_pkt(1'b0, int'($urandom_range(1, 6)), int'($urandom_range(0, 127)));
            for (int i = 0; i < 500; i++)
                send_pkt(1'b1, int'($urandom_range(1, 6)), int'($urandom_range(0, 127)));
        join
        rand_ready = 1'b0;
        wait_idle("rnd_idle");
        check("rnd_cnt0", 32'(16'(pkt_cnt0 - snap0)), 32'd500);
        check("rnd_cnt1", 32'(16'(pkt_cnt1 - snap1)), 32'd500);
        check("sb_drained_s0", 32'(exp0_q.size()), 32'd0);
        check("sb_drained_s1", 32'(exp1_q.size()), 32'd0);
        check("rnd_stall", 32'(stall_err), 32'd0);

        // Reset mid-packet: every output drops immediately, packet discarded
        mon_on = 1'b0;
        s0_tdata = 8'h11; s0_tlast = 1'b0; s0_tvalid = 1'b1;
        repeat (4) @(negedge aclk);
        check("mr_in_flight", 32'(m_tvalid), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("mr_m_tvalid", 32'(m_tvalid), 32'd0);
        check("mr_m_tlast", 32'(m_tlast), 32'd0);
        check("mr_m_tdata", 32'(m_tdata), 32'd0);
        check("mr_grant", 32'(grant), 32'd0);
        check("mr_s0_tready", 32'(s0_tready), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_cnt0", 32'(pkt_cnt0), 32'd0);
        check("mr_cnt1", 32'(pkt_cnt1), 32'd0);
        s0_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
